// File: rtl/gun_heat_controller.sv
// rtl/gun_heat_controller.sv - gun heat/cooldown controller with overheat lockout
module gun_heat_controller #(
  parameter int HEAT_W       = 4,
  parameter int CNT_W        = 28,
  parameter int FIRE_PERIOD  = 49_999_999,
  parameter int COOL_PERIOD  = 99_999_999,
  parameter int RESUME_LEVEL = 4,
  parameter int WARN_LEVEL   = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shoot,
  output logic              fire_pulse,
  output logic [HEAT_W-1:0] heat,
  output logic              heat_warn,
  output logic              overheated,
  output logic              fire_ok
);

  localparam logic [HEAT_W-1:0] HEAT_MAX    = '1;
  localparam logic [HEAT_W-1:0] RESUME      = HEAT_W'(RESUME_LEVEL);
  localparam logic [HEAT_W-1:0] WARN        = HEAT_W'(WARN_LEVEL);
  localparam logic [CNT_W-1:0]  FIRE_RELOAD = CNT_W'(FIRE_PERIOD);
  localparam logic [CNT_W-1:0]  COOL_RELOAD = CNT_W'(COOL_PERIOD);

  typedef enum logic {READY, LOCKED} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   fire_div, fire_div_n;
  logic [CNT_W-1:0]   cool_div, cool_div_n;
  logic [HEAT_W-1:0]  heat_n;
  logic               pulse_n;
  logic               warn_n;
  logic               fire_tick;
  logic               cool_tick;

  // Fire ticks only while READY and held; the cool tick is free-running.
  assign fire_tick  = (state == READY) && shoot && (fire_div == '0);
  assign cool_tick  = (cool_div == '0);
  assign overheated = (state == LOCKED);
  assign fire_ok    = (state == READY);

  // State, dividers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= READY;
      heat       <= '0;
      fire_pulse <= 1'b0;
      heat_warn  <= 1'b0;
      fire_div   <= '0;
      cool_div   <= COOL_RELOAD;
    end else begin
      state      <= state_n;
      heat       <= heat_n;
      fire_pulse <= pulse_n;
      heat_warn  <= warn_n;
      fire_div   <= fire_div_n;
      cool_div   <= cool_div_n;
    end
  end

  // Next-state, heat arithmetic and divider reloads.
  always_comb begin
    state_n    = state;
    heat_n     = heat;
    pulse_n    = 1'b0;
    fire_div_n = '0;
    cool_div_n = cool_tick ? COOL_RELOAD : cool_div - 1'b1;

    // Dropping shoot or leaving READY re-arms the fire divider so the
    // next accepted press fires immediately.
    if (state == READY && shoot) begin
      fire_div_n = fire_tick ? FIRE_RELOAD : fire_div - 1'b1;
    end

    case (state)
      READY: begin
        if (shoot) begin
          // Holding the trigger blocks cooling, even on a cool tick.
          if (fire_tick && heat != HEAT_MAX) begin
            pulse_n = 1'b1;
            heat_n  = heat + 1'b1;
            if (heat_n == HEAT_MAX) begin
              state_n = LOCKED;
            end
          end
        end else if (cool_tick && heat != '0) begin
          heat_n = heat - 1'b1;
        end
      end
      LOCKED: begin
        if (cool_tick && heat != '0) begin
          heat_n = heat - 1'b1;
          if (heat_n <= RESUME) begin
            state_n = READY;
          end
        end
      end
      default: state_n = READY;
    endcase

    warn_n = (heat_n >= WARN);
  end

endmodule

// File: tb/tb_gun_heat_controller.sv
// tb/tb_gun_heat_controller.sv - randomized model-checked bench for gun_heat_controller
module tb_gun_heat_controller;

  localparam int FP = 3;
  localparam int CP = 7;
  localparam int HMAX = 15;
  localparam int RESUME = 4;
  localparam int WARN = 12;

  logic       clock = 1'b0;
  logic       reset;
  logic       shoot;
  logic       fire_pulse;
  logic [3:0] heat;
  logic       heat_warn;
  logic       overheated;
  logic       fire_ok;

  int checks = 0;
  int errors = 0;

  gun_heat_controller #(
    .HEAT_W(4), .CNT_W(28), .FIRE_PERIOD(FP), .COOL_PERIOD(CP),
    .RESUME_LEVEL(RESUME), .WARN_LEVEL(WARN)
  ) dut (
    .clock(clock), .reset(reset), .shoot(shoot), .fire_pulse(fire_pulse),
    .heat(heat), .heat_warn(heat_warn), .overheated(overheated), .fire_ok(fire_ok)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts edges since reset, run counts consecutive
  // READY edges with shoot held; shots land on run = 1, 1+(FP+1), ...
  int m_heat = 0, m_t = 0, m_run = 0;
  bit m_locked = 0, m_pulse = 0, m_valid = 0;

  always @(posedge clock) begin : model
    int h, t, r;
    bit lk, p, cool;
    if (reset) begin
      m_heat <= 0; m_t <= 0; m_run <= 0; m_locked <= 0; m_pulse <= 0; m_valid <= 1;
    end else if (m_valid) begin
      h = m_heat; t = m_t + 1; r = m_run; lk = m_locked; p = 0;
      cool = (t % (CP + 1)) == 0;
      if (!lk) begin
        if (shoot) begin
          r = r + 1;
          if ((r - 1) % (FP + 1) == 0) begin
            p = 1;
            h = h + 1;
            if (h == HMAX) lk = 1;
          end
        end else begin
          r = 0;
          if (cool && h > 0) h = h - 1;
        end
      end else begin
        r = 0;
        if (cool) begin
          h = h - 1;
          if (h <= RESUME) lk = 0;
        end
      end
      m_heat <= h; m_t <= t; m_run <= r; m_locked <= lk; m_pulse <= p;
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clock) begin
    if (m_valid) begin
      check("m_fire_pulse", fire_pulse, m_pulse);
      check("m_heat", heat, m_heat);
      check("m_heat_warn", heat_warn, m_heat >= WARN);
      check("m_overheated", overheated, m_locked);
      check("m_fire_ok", fire_ok, !m_locked);
    end
  end

  initial begin : watchdog
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, pulses, bias;
    reset = 1'b1;
    shoot = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_heat", heat, 0);
    check("rst_fire_ok", fire_ok, 1);
    check("rst_overheated", overheated, 0);
    check("rst_pulse", fire_pulse, 0);
    check("rst_warn", heat_warn, 0);
    reset = 1'b0;

    // Hold the trigger until lockout.
    shoot = 1'b1; n = 0; pulses = 0;
    while (!overheated && n < 200) begin
      @(negedge clock); n++;
      if (fire_pulse) pulses++;
    end
    check("hold_pulses", pulses, 15);
    check("hold_heat", heat, 15);
    check("hold_overheated", overheated, 1);
    check("hold_fire_ok", fire_ok, 0);

    // Still held while locked: no shots until resume at heat 4.
    n = 0; pulses = 0;
    while (!fire_ok && n < 200) begin
      @(negedge clock); n++;
      if (fire_pulse) pulses++;
    end
    check("lock_pulses", pulses, 0);
    check("resume_heat", heat, 4);
    check("resume_fire_ok", fire_ok, 1);
    @(negedge clock);
    check("resume_shot", fire_pulse, 1);
    check("resume_shot_heat", heat, 5);

    // Cool to the floor and stay there.
    shoot = 1'b0; n = 0;
    while (heat != 0 && n < 100) begin
      @(negedge clock); n++;
    end
    repeat (40) @(negedge clock);
    check("floor_heat", heat, 0);

    // One-cycle taps: every high sample fires.
    pulses = 0;
    repeat (10) begin
      shoot = 1'b1; @(negedge clock); if (fire_pulse) pulses++;
      shoot = 1'b0; @(negedge clock); if (fire_pulse) pulses++;
    end
    check("tap_pulses", pulses, 10);

    // Reset in the middle of a lockout at heat 13.
    shoot = 1'b1; n = 0;
    while (!overheated && n < 100) begin
      @(negedge clock); n++;
    end
    shoot = 1'b0; n = 0;
    while (heat != 13 && n < 100) begin
      @(negedge clock); n++;
    end
    check("pre_rst_locked", overheated, 1);
    check("pre_rst_heat", heat, 13);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("lockrst_heat", heat, 0);
    check("lockrst_overheated", overheated, 0);
    check("lockrst_fire_ok", fire_ok, 1);
    check("lockrst_pulse", fire_pulse, 0);
    shoot = 1'b1;
    @(negedge clock);
    check("post_rst_shot_heat", heat, 1);
    shoot = 1'b0;
    repeat (6) @(negedge clock);
    check("cool_not_yet", heat, 1);
    @(negedge clock);
    check("cool_at_8", heat, 0);

    // Random bursts with varying trigger bias and rare resets.
    bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) bias = $urandom_range(0, 4);
      shoot = ($urandom_range(0, 3) < bias);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    shoot = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
